shot_clock_controller: RTL
==========================

// Module: shot_clock_controller
// PURPOSE
//  Control side of the scoreboard shot clock. Turns referee button pulses into
//  counter commands: load value + load strobe, 1 Hz decrement tick, run enable.
//  Watches the counter's current value and drives the horn when it reaches zero.
//  Sits between the debounced button block and the shot-clock countdown counter.
// PARAMETERS
//  CLK_HZ       50_000_000  clock_in cycles per tick_out period (1 s)
//  FULL_VALUE   24          load value for a new possession (5-bit, <=31)
//  SHORT_VALUE  14          load value after an offensive rebound (5-bit, <=31)
//  HORN_CYCLES  25_000_000  horn pulse length in clock_in cycles (>=1)
// PORTS
//  clock_in     in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high
//  btn_start    in   1  one-cycle pulse: start/resume countdown
//  btn_pause    in   1  one-cycle pulse: pause countdown
//  btn_reset24  in   1  one-cycle pulse: load FULL_VALUE
//  btn_reset14  in   1  one-cycle pulse: load SHORT_VALUE
//  count_in     in   5  current value from the countdown counter
//  load_value   out  5  value to load; valid while load_strobe=1
//  load_strobe  out  1  one-cycle load command to counter
//  tick_out     out  1  one-cycle decrement strobe, once per CLK_HZ cycles
//  run_en       out  1  1 while state=RUNNING
//  horn         out  1  horn drive
//  state_out    out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
// BEHAVIOUR
//  - Reset: state IDLE; prescaler=0; horn timer=0; every output 0 except
//    load_value=FULL_VALUE. All outputs are registered.
//  - Button priority in one cycle: reset24 > reset14 > pause > start.
//  - Load commands (any state): next cycle load_strobe=1, load_value=selected
//    value. Prescaler is cleared. Horn is cleared.
//    State after a load: RUNNING stays RUNNING; PAUSED stays PAUSED;
//    IDLE stays IDLE; EXPIRED goes to IDLE.
//  - IDLE: start -> RUNNING with prescaler cleared.
//  - RUNNING:
//    - The prescaler counts 0..CLK_HZ-1. At terminal count, tick_out=1 for
//      one cycle and the prescaler wraps to 0.
//    - The first tick comes CLK_HZ cycles after entry from IDLE.
//    - pause -> PAUSED. start is ignored.
//  - PAUSED: the prescaler holds its value (no tick). start -> RUNNING and
//    counting resumes from the held value.
//  - Expiry: in RUNNING, if count_in==0 and no load is pending this cycle ->
//    EXPIRED. In the next cycle horn=1 and run_en=0.
//    tick_out is suppressed from the cycle count_in==0 is seen.
//  - EXPIRED:
//    - horn stays high for exactly HORN_CYCLES, then goes 0.
//    - start and pause are ignored. Only a load leaves EXPIRED.
//  - Load and count_in==0 in the same cycle: the load wins and there is
//    no expiry.
//  - count_in==0 in IDLE or PAUSED: no expiry and no horn.
//  - reset mid-operation (RUNNING, or horn active): everything returns to its
//    reset value next cycle. The horn is cut immediately.
//  - Prescaler width is $clog2(CLK_HZ). Horn timer width is $clog2(HORN_CYCLES+1).
// CONFIGURATION
//  SHOT_CLOCK_AUTO_RESTART_EN
//   defined: when the horn pulse ends, the block issues load_strobe with
//     FULL_VALUE and enters RUNNING with the prescaler cleared (automatic
//     possession change).
//   undefined: the block stays in EXPIRED with horn=0 until a load button.
// TESTING (CLK_HZ=4, HORN_CYCLES=3 unless noted)
//  1 reset held 2 cycles -> state_out=00, all outputs 0, load_value=24.
//  2 btn_reset24 then btn_start, count_in=5 -> load_strobe 1 cycle with
//    load_value=24; tick_out every 4th cycle, first one 4 cycles after RUNNING.
//  3 RUNNING, pause after 2 prescaler counts, start 10 cycles later -> no tick
//    while PAUSED; next tick 2 cycles after resume.
//  4 RUNNING, count_in driven to 0 -> state_out=11, horn=1 for exactly 3 cycles,
//    no tick_out; btn_start ignored; btn_reset14 -> load_value=14, state IDLE.
//  5 btn_reset24+btn_pause+btn_start in the same cycle while count_in=0 in
//    RUNNING -> load 24, no expiry, state stays RUNNING.
//  6 SHOT_CLOCK_AUTO_RESTART_EN defined, expiry -> after 3 horn cycles:
//    load_strobe, load_value=24, state_out=01; also check reset asserted
//    during the horn -> horn=0 next cycle.

Source files
------------

// File: rtl/shot_clock_controller.sv
// shot_clock_controller: button-to-counter command FSM with 1 Hz tick and horn; optional SHOT_CLOCK_AUTO_RESTART_EN reloads FULL_VALUE and resumes when the horn ends
module shot_clock_controller #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int FULL_VALUE  = 24,
    parameter int SHORT_VALUE = 14,
    parameter int HORN_CYCLES = 25_000_000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_reset24,
    input  logic       btn_reset14,
    input  logic [4:0] count_in,
    output logic [4:0] load_value,
    output logic       load_strobe,
    output logic       tick_out,
    output logic       run_en,
    output logic       horn,
    output logic [1:0] state_out
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] RUNNING = 2'b01;
    localparam logic [1:0] PAUSED  = 2'b10;
    localparam logic [1:0] EXPIRED = 2'b11;
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam int HW = $clog2(HORN_CYCLES + 1);

    logic [PW-1:0] presc;
    logic [HW-1:0] horn_timer;
    logic          load;
    logic [4:0]    load_sel;

    // load request and its value, reset24 taking precedence over reset14
    always_comb begin
        load     = btn_reset24 | btn_reset14;
        load_sel = btn_reset24 ? 5'(FULL_VALUE) : 5'(SHORT_VALUE);
    end

    // state, prescaler, horn timer and registered outputs
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_out   <= IDLE;
            presc       <= '0;
            horn_timer  <= '0;
            load_value  <= 5'(FULL_VALUE);
            load_strobe <= 1'b0;
            tick_out    <= 1'b0;
            run_en      <= 1'b0;
            horn        <= 1'b0;
        end else begin
            load_strobe <= 1'b0;
            tick_out    <= 1'b0;
            if (load) begin
                load_strobe <= 1'b1;
                load_value  <= load_sel;
                presc       <= '0;
                horn_timer  <= '0;
                horn        <= 1'b0;
                if (state_out == EXPIRED) state_out <= IDLE;
            end else begin
                case (state_out)
                    IDLE: if (btn_start) begin
                        state_out <= RUNNING;
                        presc     <= '0;
                        run_en    <= 1'b1;
                    end
                    RUNNING: if (count_in == 5'd0) begin
                        state_out  <= EXPIRED;
                        run_en     <= 1'b0;
                        horn       <= 1'b1;
                        horn_timer <= HW'(HORN_CYCLES);
                    end else if (btn_pause) begin
                        state_out <= PAUSED;
                        run_en    <= 1'b0;
                    end else if (presc == PW'(CLK_HZ - 1)) begin
                        presc    <= '0;
                        tick_out <= 1'b1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                    PAUSED: if (btn_start) begin
                        state_out <= RUNNING;
                        run_en    <= 1'b1;
                    end
                    default: if (horn_timer != '0) begin
                        horn_timer <= horn_timer - HW'(1);
                        horn       <= horn_timer > HW'(1);
`ifdef SHOT_CLOCK_AUTO_RESTART_EN
                        if (horn_timer == HW'(1)) begin
                            load_strobe <= 1'b1;
                            load_value  <= 5'(FULL_VALUE);
                            state_out   <= RUNNING;
                            presc       <= '0;
                            run_en      <= 1'b1;
                        end
`else
`endif
                    end
                endcase
            end
        end
    end
endmodule
